uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the core's data port, alongside `Memory`: it decodes data-bus writes to its address window, buffers the bytes and serialises them 8N1 on a pin. It gives programs running on the core a console and status output beyond the single exit LED. Reads return a status word, and the block never stalls the core.

---
 rtl/uart_tx_mmio.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a status register on the core data port.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX buffer; otherwise a single holding register buffers one byte.
module uart_tx_mmio #(
  parameter int unsigned         WORD_LEN    = 32,
  parameter int unsigned         CLK_FREQ    = 27000000,
  parameter int unsigned         BAUD_RATE   = 115200,
  parameter int unsigned         FIFO_DEPTH  = 16,
  parameter logic [WORD_LEN-1:0] TX_ADDR     = WORD_LEN'(32'h0000_1000),
  parameter logic [WORD_LEN-1:0] STATUS_ADDR = WORD_LEN'(32'h0000_1004)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                wen,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] rdata,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_mmio: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_mmio: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_d;
  logic               ovf;

  logic               full, empty;
  logic [7:0]         head;
  logic               push_req_c, push_c, pop_c, clr_ovf_c, bit_end_c;

  logic               unused_wdata;
  assign unused_wdata = ^wdata[WORD_LEN-1:8];

  // Bus decode: fullness is the pre-edge value, so a same-cycle pop never makes room.
  assign push_req_c = wen && (d_addr == TX_ADDR);
  assign push_c     = push_req_c && !full;
  assign clr_ovf_c  = wen && (d_addr == STATUS_ADDR) && wdata[2];
  assign bit_end_c  = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= wdata[7:0];
  end
`else
  logic       hold_vld;
  logic [7:0] hold_q;

  assign empty = !hold_vld;
  assign full  = hold_vld;
  assign head  = hold_q;

  // Depth-1 buffer: push only when empty, so push and pop never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (push_c) begin
      hold_vld <= 1'b1;
      hold_q   <= wdata[7:0];
    end else if (pop_c) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push_req_c && full) begin
      ovf <= 1'b1;
    end else if (clr_ovf_c) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

  // Frame sequencer; tx is registered from the next-state values so it changes with the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop_c   = 1'b1;
          shift_d = head;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign busy  = (state_q != IDLE) || !empty;
  assign rdata = (d_addr == STATUS_ADDR) ? WORD_LEN'({ovf, busy, full}) : '0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio at 4 clocks per bit.
module tb_uart_tx_mmio;

  localparam int unsigned SW          = 256;
  localparam logic [31:0] TX_ADDR     = 32'h0000_1000;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_addr, wdata, rdata;
  logic        wen, tx, busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [SW-1:0] got;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .WORD_LEN   (32),
    .CLK_FREQ   (4),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4),
    .TX_ADDR    (TX_ADDR),
    .STATUS_ADDR(STATUS_ADDR)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .d_addr(d_addr),
    .wen   (wen),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .busy  (busy)
  );

  task automatic check_eq(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus write; the accepting edge is the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    d_addr = a;
    wdata  = d;
    wen    = 1'b1;
    @(posedge clk);
    #1;
    wen    = 1'b0;
    d_addr = '0;
    wdata  = '0;
  endtask

  task automatic rd_status(input string tag, input logic [2:0] exp);
    d_addr = STATUS_ADDR;
    #1;
    check_eq(tag, SW'(rdata), SW'(exp));
    d_addr = '0;
  endtask

  // Sample tx at n successive falling edges; bit j is the j-th sample.
  task automatic capture(input int n, output logic [SW-1:0] v);
    v = '0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      v[j] = tx;
    end
  endtask

  // Expected line: one idle sample, then per byte 4 start, 32 data (LSB first), 4 stop, 1 idle.
  function automatic logic [SW-1:0] exp_stream(input logic [47:0] bytes, input int n);
    logic [SW-1:0] v;
    logic [7:0]    b;
    int            idx;
    v    = '0;
    v[0] = 1'b1;
    idx  = 1;
    for (int k = 0; k < n; k++) begin
      b = bytes[8*k +: 8];
      for (int j = 0; j < 41; j++) begin
        if (j < 4)       v[idx] = 1'b0;
        else if (j < 36) v[idx] = b[(j-4)/4];
        else             v[idx] = 1'b1;
        idx++;
      end
    end
    return v;
  endfunction

  function automatic logic [SW-1:0] ones(input int n);
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    wen    = 1'b0;
    d_addr = '0;
    wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tx", SW'(tx), SW'(1'b1));
    check_eq("reset_busy", SW'(busy), SW'(1'b0));
    rd_status("reset_status", 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single byte 0x55, upper word bits ignored.
    wr(TX_ADDR, 32'hDEAD_BE55);
    check_eq("busy_after_push", SW'(busy), SW'(1'b1));
    capture(42, got);
    check_eq("frame_55", got, exp_stream(48'h55, 1));
    check_eq("busy_after_55", SW'(busy), SW'(1'b0));

    // Two frames back to back with a single idle cycle between them.
    wr(TX_ADDR, 32'h41);
    fork
      capture(83, got);
      begin
        @(posedge clk);
        #1;
        wr(TX_ADDR, 32'h42);
      end
    join
    check_eq("frames_41_42", got, exp_stream(48'h4241, 2));
    check_eq("busy_after_41_42", SW'(busy), SW'(1'b0));

`ifdef UART_TX_FIFO_EN
    // Depth 4: byte 1 is popped at once, bytes 2-5 fill the FIFO, byte 6 is dropped.
    wr(TX_ADDR, 32'hFFFF_FF11);
    fork
      capture(1 + 41*5, got);
      begin
        wr(TX_ADDR, 32'h22);
        wr(TX_ADDR, 32'h33);
        wr(TX_ADDR, 32'h44);
        wr(TX_ADDR, 32'h55);
        wr(TX_ADDR, 32'h66);
        rd_status("status_full_ovf", 3'b111);
      end
    join
    check_eq("frames_overflow", got, exp_stream(48'h55_4433_2211, 5));
`else
    // Holding register: byte 2 meets a full buffer at its edge and is dropped.
    wr(TX_ADDR, 32'hFFFF_FF11);
    fork
      capture(83, got);
      begin
        wr(TX_ADDR, 32'h22);
        wr(TX_ADDR, 32'h33);
        rd_status("status_full_ovf", 3'b111);
      end
    join
    check_eq("frames_overflow", got, exp_stream(48'h3311, 2));
`endif
    check_eq("busy_after_overflow", SW'(busy), SW'(1'b0));
    rd_status("status_ovf_sticky", 3'b100);
    d_addr = TX_ADDR;
    #1;
    check_eq("rdata_tx_addr", SW'(rdata), SW'(0));
    wr(STATUS_ADDR, 32'hFFFF_FFFB);
    rd_status("ovf_kept_bit2_low", 3'b100);
    wr(STATUS_ADDR, 32'h0000_0004);
    rd_status("ovf_cleared", 3'b000);

    // Reset in the middle of data bit 3 of 0xA5 with 0x3C queued behind it.
    wr(TX_ADDR, 32'hA5);
    @(posedge clk);
    #1;
    wr(TX_ADDR, 32'h3C);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check_eq("tx_data_bit3", SW'(tx), SW'(1'b0));
    d_addr = STATUS_ADDR;
    #1;
    rst = 1'b1;
    #1;
    check_eq("tx_async_reset", SW'(tx), SW'(1'b1));
    check_eq("busy_async_reset", SW'(busy), SW'(1'b0));
    check_eq("status_async_reset", SW'(rdata), SW'(0));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    d_addr = '0;
    capture(50, got);
    check_eq("line_idle_after_reset", got, ones(50));
    check_eq("busy_idle_after_reset", SW'(busy), SW'(1'b0));

    // Unmapped addresses: no readback, no transmission.
    d_addr = 32'h0000_2000;
    #1;
    check_eq("rdata_unmapped", SW'(rdata), SW'(0));
    wr(32'h0000_1008, 32'hFF);
    check_eq("busy_unmapped_write", SW'(busy), SW'(1'b0));
    capture(12, got);
    check_eq("line_idle_unmapped", got, ones(12));
    rd_status("status_unmapped", 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
